mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multicycle controller FSM that sits directly upstream of the 32-bit ALU.
- Decodes opcode/funct from the instruction register and drives alu_ctrl.
- Also drives the datapath mux selects, register-file write, memory strobes and PC enable, one microstep per clock.
- Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.

Parameters:
- MEM_WAIT, 0: extra wait cycles in each memory-access state (FETCH, MEM_READ, MEM_WRITE). Each of these states lasts MEM_WAIT+1 cycles. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- alu_ctrl  out  3  ALU operation: AND=000, OR=001, ADD=010, SUB=110, SLT=111
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_en  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  write-back data select: 0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- halted  out  1  illegal-instruction halt indicator

Behaviour:
- Reset: while rst_n=0, every output is 0, state=FETCH and the wait counter is 0. First active edge after release is the first FETCH cycle.
- Outputs are Moore, decoded from state. Exception: pc_en in BRANCH equals zero (combinational). Any output not listed for a state is 0.
- Wait counter: counts 0..MEM_WAIT in FETCH, MEM_READ and MEM_WRITE, and clears on exit. The state exits only when count==MEM_WAIT.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00. On the last cycle only: ir_write=1, pc_en=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target). Latch a 3-bit op class from opcode/funct. Next state:
  - 000000 with a legal funct -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> ADDI_EXEC
  - 000010 -> JUMP
  - anything else -> ILLEGAL
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl is taken from the latched funct: 100000=ADD, 100010=SUB, 100100=AND, 100101=OR, 101010=SLT. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1, held MEM_WAIT+1 cycles. Next state is MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state is FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, held MEM_WAIT+1 cycles. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01, pc_en=zero. Next state is FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next state is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- JUMP: pc_src=10, pc_en=1. Next state is FETCH.
- Cycles per instruction (MEM_WAIT=0): R=4, lw=5, sw=4, beq=3, addi=4, j=3. Each memory state adds MEM_WAIT cycles.
- Opcode/funct are sampled only in DECODE. Changes in other states have no effect.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronous). Any partial write strobe is abandoned and execution restarts at FETCH.
- mem_read and mem_write are never asserted together. reg_write and pc_en are never asserted together.
- Unreachable state encodings -> FETCH.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: the ILLEGAL state sets halted=1, all other outputs 0, and stays there until rst_n is asserted.
- Undefined: ILLEGAL lasts one cycle with all outputs 0, then goes to FETCH (instruction treated as nop). halted is tied to 0.

Test Plan:
- Reset then release, MEM_WAIT=0 -> first cycle: mem_read=1, ir_write=1, pc_en=1, alu_ctrl=010. While rst_n=0, all outputs are 0.
- R-type opcode 000000, funct 101010 -> R_EXEC alu_ctrl=111, alu_src_a=1, alu_src_b=00. Next cycle reg_write=1, reg_dst=1. 4 cycles total.
- lw (100011) with MEM_WAIT=2 -> FETCH 3 cycles (ir_write on the 3rd only), MEM_READ 3 cycles with i_or_d=1, then MEM_WB mem_to_reg=1. 9 cycles total.
- beq (000100), zero=1 then repeat with zero=0 -> BRANCH alu_ctrl=110, pc_src=01; pc_en=1 and 0 respectively.
- j (000010) -> JUMP pc_src=10, pc_en=1, then FETCH. Mid-instruction rst_n pulse in MEM_WRITE -> mem_write drops to 0 without waiting for a clock edge.
- Opcode 111111 -> with MC_CTRL_ILLEGAL_TRAP_EN: halted=1 held for 20 cycles, no strobes. Without the macro: one idle cycle, then FETCH.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control bus between the multicycle controller and the 32-bit datapath.
// The controller is the master: it reads opcode/funct/zero and drives every strobe.
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;

    modport master (
        input  opcode, funct, zero,
        output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, halted
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, halted
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset controller: one microstep per clock, registered Moore outputs.
// Optional MC_CTRL_ILLEGAL_TRAP_EN makes illegal instructions halt until reset.
module mc_control_unit #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_control_unit_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LW, OP_SW, OP_NONE
    } op_t;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    op_t        op_q, op_d;
    logic       run_q;
    ctrl_t      ctrl_q, ctrl_d;
    logic       cnt_last;

    // Outputs for a given (state, wait count, op class); registered so they line up with state_q.
    function automatic ctrl_t decode(state_t s, logic [3:0] cnt, op_t op);
        ctrl_t c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctrl  = ALU_ADD;
                if (cnt == WAIT_LAST) begin
                    c.ir_write = 1'b1;
                    c.pc_en    = 1'b1;
                end
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctrl  = ALU_ADD;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                case (op)
                    OP_SUB:  c.alu_ctrl = ALU_SUB;
                    OP_AND:  c.alu_ctrl = ALU_AND;
                    OP_OR:   c.alu_ctrl = ALU_OR;
                    OP_SLT:  c.alu_ctrl = ALU_SLT;
                    default: c.alu_ctrl = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = ALU_SUB;
                c.pc_src    = 2'b01;
            end
            S_ADDI_WB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src = 2'b10;
                c.pc_en  = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL: c.halted = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction

    assign cnt_last = (cnt_q == WAIT_LAST);

    // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        if (!run_q) begin
            // First edge after reset only arms the FSM so FETCH starts with count 0.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:     if (cnt_last) state_d = S_DECODE;    else cnt_d = cnt_q + 4'd1;
                S_MEM_READ:  if (cnt_last) state_d = S_MEM_WB;    else cnt_d = cnt_q + 4'd1;
                S_MEM_WRITE: if (cnt_last) state_d = S_FETCH;     else cnt_d = cnt_q + 4'd1;
                S_DECODE: begin
                    op_d    = OP_NONE;
                    state_d = S_ILLEGAL;
                    case (bus.opcode)
                        6'b000000: begin
                            state_d = S_R_EXEC;
                            case (bus.funct)
                                6'b100000: op_d = OP_ADD;
                                6'b100010: op_d = OP_SUB;
                                6'b100100: op_d = OP_AND;
                                6'b100101: op_d = OP_OR;
                                6'b101010: op_d = OP_SLT;
                                default:   state_d = S_ILLEGAL;
                            endcase
                        end
                        6'b100011: begin op_d = OP_LW; state_d = S_MEM_ADDR; end
                        6'b101011: begin op_d = OP_SW; state_d = S_MEM_ADDR; end
                        6'b000100: state_d = S_BRANCH;
                        6'b001000: state_d = S_ADDI_EXEC;
                        6'b000010: state_d = S_JUMP;
                        default:   state_d = S_ILLEGAL;
                    endcase
                end
                S_R_EXEC:    state_d = S_R_WB;
                S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_ADDI_EXEC: state_d = S_ADDI_WB;
                S_R_WB, S_MEM_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_ILLEGAL:   state_d = S_ILLEGAL;
`else
                S_ILLEGAL:   state_d = S_FETCH;
`endif
                default:     state_d = S_FETCH;
            endcase
        end
        ctrl_d = decode(state_d, cnt_d, op_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            run_q   <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            run_q   <= 1'b1;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.alu_ctrl   = ctrl_q.alu_ctrl;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.pc_src     = ctrl_q.pc_src;
    // Branch decision is the one combinational path: zero arrives during the BRANCH cycle itself.
    assign bus.pc_en      = ctrl_q.pc_en | ((state_q == S_BRANCH) & bus.zero);
    assign bus.i_or_d     = ctrl_q.i_or_d;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.ir_write   = ctrl_q.ir_write;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.halted     = ctrl_q.halted;
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: two instances (MEM_WAIT=0 and 2) run against an instruction-level
// model that expands each instruction into its expected per-cycle control vector.
module tb_mc_control_unit;
    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
    } exp_t;

    typedef struct packed {
        exp_t       o;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       zero;
    } step_t;

    localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011;
    localparam logic [5:0] OPC_BEQ = 6'b000100, OPC_ADDI = 6'b001000, OPC_J = 6'b000010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_unit_if if0();
    mc_control_unit_if if2();

    mc_control_unit #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mc_control_unit #(.MEM_WAIT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    exp_t act0, act2;
    assign act0 = {if0.alu_ctrl, if0.alu_src_a, if0.alu_src_b, if0.pc_src, if0.pc_en, if0.i_or_d,
                   if0.mem_read, if0.mem_write, if0.ir_write, if0.reg_dst, if0.mem_to_reg,
                   if0.reg_write, if0.halted};
    assign act2 = {if2.alu_ctrl, if2.alu_src_a, if2.alu_src_b, if2.pc_src, if2.pc_en, if2.i_or_d,
                   if2.mem_read, if2.mem_write, if2.ir_write, if2.reg_dst, if2.mem_to_reg,
                   if2.reg_write, if2.halted};

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur_test = "none";
    step_t q0[$];
    step_t q2[$];

    // Returns {legal, alu code} for an R-type funct.
    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_000;
        endcase
    endfunction

    task automatic push(input int which, input exp_t o, input logic [5:0] op, input logic [5:0] fn,
                        input logic z);
        step_t s;
        s.o = o; s.opcode = op; s.funct = fn; s.zero = z;
        if (which == 0) q0.push_back(s); else q2.push_back(s);
    endtask

    // Inputs outside DECODE (and zero outside BRANCH) are random: they must be ignored.
    task automatic push_rnd(input int which, input exp_t o);
        push(which, o, 6'($urandom), 6'($urandom), 1'($urandom));
    endtask

    task automatic model_instr(input int which, input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
        int         mw;
        exp_t       o;
        logic [3:0] r;
        mw = (which == 0) ? 0 : 2;
        r  = r_alu(fn);
        for (int k = 0; k <= mw; k++) begin
            o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
            if (k == mw) begin o.ir_write = 1'b1; o.pc_en = 1'b1; end
            push_rnd(which, o);
        end
        o = '0; o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010;
        push(which, o, op, fn, 1'($urandom));
        if (op == OPC_R && r[3]) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = r[2:0]; push_rnd(which, o);
            o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1;    push_rnd(which, o);
        end else if (op == OPC_LW || op == OPC_SW) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; push_rnd(which, o);
            for (int k = 0; k <= mw; k++) begin
                o = '0; o.i_or_d = 1'b1;
                if (op == OPC_LW) o.mem_read = 1'b1; else o.mem_write = 1'b1;
                push_rnd(which, o);
            end
            if (op == OPC_LW) begin
                o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; push_rnd(which, o);
            end
        end else if (op == OPC_BEQ) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.pc_en = z;
            push(which, o, 6'($urandom), 6'($urandom), z);
        end else if (op == OPC_ADDI) begin
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; push_rnd(which, o);
            o = '0; o.reg_write = 1'b1; push_rnd(which, o);
        end else if (op == OPC_J) begin
            o = '0; o.pc_src = 2'b10; o.pc_en = 1'b1; push_rnd(which, o);
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            o = '0; o.halted = 1'b1;
            for (int k = 0; k < 20; k++) push_rnd(which, o);
`else
            o = '0; push_rnd(which, o);
`endif
        end
    endtask

    task automatic model_both(input logic [5:0] op, input logic [5:0] fn, input logic z);
        model_instr(0, op, fn, z);
        model_instr(2, op, fn, z);
    endtask

    // Entered just after a rising edge; each iteration is one clock cycle per instance.
    task automatic run_streams(input int max_cycles);
        step_t s0, s2;
        bit    v0, v2;
        for (int c = 0; c < max_cycles && (q0.size() > 0 || q2.size() > 0); c++) begin
            v0 = (q0.size() > 0);
            v2 = (q2.size() > 0);
            s0 = v0 ? q0.pop_front() : step_t'($urandom);
            s2 = v2 ? q2.pop_front() : step_t'($urandom);
            if0.opcode = s0.opcode; if0.funct = s0.funct; if0.zero = s0.zero;
            if2.opcode = s2.opcode; if2.funct = s2.funct; if2.zero = s2.zero;
            @(negedge clk);
            if (v0) begin
                n_checks++;
                if (act0 !== s0.o) begin
                    n_fail++;
                    $display("FAIL %s dut0 cycle %0d: got %h expected %h", cur_test, c, act0, s0.o);
                end
            end
            if (v2) begin
                n_checks++;
                if (act2 !== s2.o) begin
                    n_fail++;
                    $display("FAIL %s dut2 cycle %0d: got %h expected %h", cur_test, c, act2, s2.o);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q2.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if0.opcode = 6'($urandom); if0.funct = 6'($urandom); if0.zero = 1'b1;
            if2.opcode = 6'($urandom); if2.funct = 6'($urandom); if2.zero = 1'b1;
            @(negedge clk);
            n_checks++;
            if (act0 !== '0 || act2 !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: got %h/%h expected 0", act0, act2);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        q0.delete(); q2.delete();
        model_both(OPC_R, 6'b101010, 1'b0);
        run_streams(100);
    endtask

    task automatic test_rtype();
        logic [5:0] fns [5];
        cur_test = "rtype";
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        do_reset();
        foreach (fns[i]) model_both(OPC_R, fns[i], 1'b0);
        run_streams(200);
    endtask

    task automatic test_mem();
        cur_test = "mem";
        do_reset();
        model_both(OPC_LW, 6'($urandom), 1'b0);
        model_both(OPC_SW, 6'($urandom), 1'b1);
        model_both(OPC_LW, 6'($urandom), 1'b1);
        run_streams(200);
    endtask

    task automatic test_branch_jump();
        cur_test = "branch_jump";
        do_reset();
        model_both(OPC_BEQ, 6'($urandom), 1'b1);
        model_both(OPC_BEQ, 6'($urandom), 1'b0);
        model_both(OPC_J, 6'($urandom), 1'b0);
        model_both(OPC_ADDI, 6'($urandom), 1'b1);
        run_streams(200);
    endtask

    task automatic test_async_reset();
        cur_test = "async_reset";
        do_reset();
        model_both(OPC_SW, 6'b0, 1'b0);
        // dut2: FETCH x3, DECODE, MEM_ADDR, then cycle 6 is the second MEM_WRITE cycle.
        run_streams(6);
        #2;
        n_checks++;
        if (if2.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_pre: mem_write got %b expected 1", if2.mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act0 !== '0 || act2 !== '0) begin
            n_fail++;
            $display("FAIL async_reset_drop: got %h/%h expected 0", act0, act2);
        end
        q0.delete(); q2.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_both(OPC_LW, 6'b0, 1'b0);
        run_streams(100);
    endtask

    task automatic test_illegal();
        cur_test = "illegal";
        do_reset();
        model_both(6'b111111, 6'($urandom), 1'b1);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        model_both(OPC_R, 6'b000001, 1'b0);
        model_both(OPC_ADDI, 6'b0, 1'b0);
`endif
        run_streams(200);
    endtask

    task automatic test_random();
        int         kind;
        logic [5:0] op, fn;
        cur_test = "random";
        do_reset();
        for (int i = 0; i < 40; i++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            kind = $urandom_range(0, 9);
`else
            kind = $urandom_range(0, 10);
`endif
            fn = 6'($urandom);
            case (kind)
                0: begin op = OPC_R; fn = 6'b100000; end
                1: begin op = OPC_R; fn = 6'b100010; end
                2: begin op = OPC_R; fn = 6'b100100; end
                3: begin op = OPC_R; fn = 6'b100101; end
                4: begin op = OPC_R; fn = 6'b101010; end
                5: op = OPC_LW;
                6: op = OPC_SW;
                7: op = OPC_BEQ;
                8: op = OPC_ADDI;
                9: op = OPC_J;
                default: op = 6'b111110;
            endcase
            model_both(op, fn, 1'($urandom));
        end
        run_streams(2000);
    endtask

    initial begin
        if0.opcode = '0; if0.funct = '0; if0.zero = 1'b0;
        if2.opcode = '0; if2.funct = '0; if2.zero = 1'b0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_async_reset();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
